// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared constants, state encoding and redirect kinds for the
// instruction-fetch program-counter generator (pc_gen) and its pending
// redirect buffer (pc_redirect_buf).
package pc_gen_pkg;

    // Value of stall_i[0] that holds the PC stage.
    localparam logic STOP = 1'b1;

    // Active level of the asynchronous reset.
    localparam logic RST_ENABLE = 1'b1;

    // Default first fetch address after reset.
    localparam int DEFAULT_RESET_VECTOR = 0;

    // PC stage states: BOOT until the first edge after reset release,
    // RUN while fetching, HOLD while the pipeline stall bit is set.
    typedef enum logic [1:0] {
        PC_BOOT = 2'd0,
        PC_RUN  = 2'd1,
        PC_HOLD = 2'd2
    } pc_state_e;

    // Kind of a redirect held in the pending buffer. Exceptions outrank
    // branches when deciding whether a pending entry may be overwritten.
    typedef enum logic {
        KIND_BRANCH = 1'b0,
        KIND_EXCP   = 1'b1
    } redir_kind_e;

endpackage

// File: rtl/pc_gen_if.sv
// pc_gen_if: fetch bus between the PC generator (master) and the
// instruction memory (slave).
//
// Handshake: ce_o is the request-valid and fetch_ready_i the ready. The
// address on pc_o is transferred on every cycle where ce_o && fetch_ready_i.
// pc_o is stable while ce_o is high and only moves on an edge where the
// address was accepted and the PC stage is not stalled, so a stalled stage
// may present (and have accepted) the same address on several cycles.
// align_err_o is a one-cycle status pulse and takes no part in the handshake.
interface pc_gen_if #(
    parameter int ADDR_WIDTH = 32
) ();
    logic [ADDR_WIDTH-1:0] pc_o;
    logic                  ce_o;
    logic                  fetch_ready_i;
    logic                  align_err_o;

    modport master (
        output pc_o,
        output ce_o,
        output align_err_o,
        input  fetch_ready_i
    );

    modport slave (
        input  pc_o,
        input  ce_o,
        input  align_err_o,
        output fetch_ready_i
    );
endinterface

// File: rtl/pc_redirect_buf.sv
// pc_redirect_buf: single-entry pending redirect register. Holds a redirect
// that arrived while the PC could not advance. An exception overwrites any
// entry; a branch overwrites only an empty slot or a pending branch, never a
// pending exception. consume clears the entry (whether it was used or
// superseded by a live redirect).
module pc_redirect_buf
    import pc_gen_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  write,
    input  redir_kind_e           kind,
    input  logic [ADDR_WIDTH-1:0] target,
    input  logic                  consume,
    output logic                  valid,
    output logic [ADDR_WIDTH-1:0] target_out
);

    logic                  valid_q;
    redir_kind_e           kind_q;
    logic [ADDR_WIDTH-1:0] target_q;
    logic                  may_write;

    // A write is allowed unless it is a branch trying to replace an exception.
    assign may_write = write &&
                       ((kind == KIND_EXCP) || !valid_q || (kind_q == KIND_BRANCH));

    // Pending entry register; write and consume never coincide in pc_gen.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i == RST_ENABLE) begin
            valid_q  <= 1'b0;
            kind_q   <= KIND_BRANCH;
            target_q <= '0;
        end else if (may_write) begin
            valid_q  <= 1'b1;
            kind_q   <= kind;
            target_q <= target;
        end else if (consume) begin
            valid_q  <= 1'b0;
        end
    end

    assign valid      = valid_q;
    assign target_out = target_q;

endmodule

// File: rtl/pc_gen.sv
// pc_gen: program-counter generator for the instruction-fetch stage.
// Produces the fetch address and fetch enable, honours the pipeline stall
// bit and the fetch-ready handshake, and applies exception/branch redirects
// (buffering one that arrives while the PC cannot advance).
// Optional feature: define PC_ALIGN_CHK_EN to get a registered one-cycle
// align_err_o pulse after any applied redirect whose raw target was not
// INST_BYTES-aligned; otherwise align_err_o is tied low.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    INST_BYTES   = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = ADDR_WIDTH'(DEFAULT_RESET_VECTOR),
    parameter int                    STALL_WIDTH  = 6
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [STALL_WIDTH-1:0] stall_i,
    input  logic                   branch_flag_i,
    input  logic [ADDR_WIDTH-1:0]  branch_target_i,
    input  logic                   excp_flag_i,
    input  logic [ADDR_WIDTH-1:0]  excp_vector_i,
    pc_gen_if.master               fetch_if,
    output pc_state_e              state_o
);

    // Low address bits that must be zero in an INST_BYTES-aligned address.
    localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'(INST_BYTES - 1);
    localparam logic [ADDR_WIDTH-1:0] PC_STEP  = ADDR_WIDTH'(INST_BYTES);

    pc_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  ce_q;
    logic                  stop;
    logic                  advance;
    logic                  redirect_req;
    redir_kind_e           live_kind;
    logic [ADDR_WIDTH-1:0] live_target;
    logic                  redirect_taken;
    logic [ADDR_WIDTH-1:0] raw_target;
    logic                  buf_write;
    logic                  buf_valid;
    logic [ADDR_WIDTH-1:0] buf_target;
    logic                  unused_stall;

    // Only the PC-stage bit of the stall vector matters here.
    assign unused_stall = ^stall_i;
    assign stop         = (stall_i[0] == STOP);

    assign advance      = (state_q == PC_RUN) && !stop && fetch_if.fetch_ready_i;
    assign redirect_req = excp_flag_i || branch_flag_i;
    assign live_kind    = excp_flag_i ? KIND_EXCP : KIND_BRANCH;
    assign live_target  = excp_flag_i ? excp_vector_i : branch_target_i;
    assign buf_write    = redirect_req && !advance;

    pc_redirect_buf #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_redirect_buf (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .write      (buf_write),
        .kind       (live_kind),
        .target     (live_target),
        .consume    (advance),
        .valid      (buf_valid),
        .target_out (buf_target)
    );

    // Next-state and next-PC: live exception, live branch, pending entry,
    // then sequential increment (wrapping modulo 2^ADDR_WIDTH).
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        redirect_taken = 1'b0;
        raw_target     = buf_target;

        case (state_q)
            PC_BOOT: state_d = PC_RUN;
            PC_RUN:  if (stop)  state_d = PC_HOLD;
            PC_HOLD: if (!stop) state_d = PC_RUN;
            default: state_d = PC_BOOT;
        endcase

        if (advance) begin
            if (redirect_req) begin
                redirect_taken = 1'b1;
                raw_target     = live_target;
            end else if (buf_valid) begin
                redirect_taken = 1'b1;
                raw_target     = buf_target;
            end
            pc_d = redirect_taken ? (raw_target & ~LOW_MASK) : (pc_q + PC_STEP);
        end
    end

    // State, PC and fetch-enable registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i == RST_ENABLE) begin
            state_q <= PC_BOOT;
            pc_q    <= RESET_VECTOR;
            ce_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ce_q    <= (state_d != PC_BOOT);
        end
    end

`ifdef PC_ALIGN_CHK_EN
    logic align_err_q;

    // One-cycle pulse after an applied redirect with nonzero low bits.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i == RST_ENABLE) begin
            align_err_q <= 1'b0;
        end else begin
            align_err_q <= redirect_taken && ((raw_target & LOW_MASK) != '0);
        end
    end

    assign fetch_if.align_err_o = align_err_q;
`else
    assign fetch_if.align_err_o = 1'b0;
`endif

    assign fetch_if.pc_o = pc_q;
    assign fetch_if.ce_o = ce_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed and randomized checks of pc_gen (16-bit PC, 4-byte
// instructions, reset vector 0x100) against a behavioural reference model.
module tb_pc_gen;
    import pc_gen_pkg::*;

    localparam int AW = 16;
    localparam logic [AW-1:0] RV = 16'h0100;
`ifdef PC_ALIGN_CHK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          rst;
    logic [5:0]    stall;
    logic          br_flag;
    logic [AW-1:0] br_tgt;
    logic          ex_flag;
    logic [AW-1:0] ex_vec;
    pc_state_e     dut_state;

    pc_gen_if #(.ADDR_WIDTH(AW)) fif ();

    always #5 clk = ~clk;

    pc_gen #(
        .ADDR_WIDTH   (AW),
        .INST_BYTES   (4),
        .RESET_VECTOR (RV),
        .STALL_WIDTH  (6)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .stall_i         (stall),
        .branch_flag_i   (br_flag),
        .branch_target_i (br_tgt),
        .excp_flag_i     (ex_flag),
        .excp_vector_i   (ex_vec),
        .fetch_if        (fif),
        .state_o         (dut_state)
    );

    // ---------------- reference model ----------------
    // mode: 0 = boot, 1 = run, 2 = hold
    int            m_mode;
    int            m_pc;
    bit            m_err;
    bit            p_valid;
    bit            p_excp;
    int            p_tgt;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic model_reset();
        m_mode  = 0;
        m_pc    = int'(RV);
        m_err   = 1'b0;
        p_valid = 1'b0;
        p_excp  = 1'b0;
        p_tgt   = 0;
    endtask

    // Effect of one rising edge given the inputs currently applied.
    task automatic model_edge();
        bit stalled;
        bit adv;
        bit have;
        int t;
        stalled = stall[0];
        adv     = (m_mode == 1) && !stalled && fif.fetch_ready_i;
        m_err   = 1'b0;
        if (adv) begin
            have = 1'b1;
            t    = 0;
            if (ex_flag)      t = int'(ex_vec);
            else if (br_flag) t = int'(br_tgt);
            else if (p_valid) t = p_tgt;
            else              have = 1'b0;
            if (have) begin
                m_pc  = (t / 4) * 4;
                m_err = ALIGN_EN && (t % 4 != 0);
            end else begin
                m_pc = (m_pc + 4) % 65536;
            end
            p_valid = 1'b0;
        end else if (ex_flag) begin
            p_valid = 1'b1;
            p_excp  = 1'b1;
            p_tgt   = int'(ex_vec);
        end else if (br_flag && !(p_valid && p_excp)) begin
            p_valid = 1'b1;
            p_excp  = 1'b0;
            p_tgt   = int'(br_tgt);
        end
        if (m_mode == 0)                 m_mode = 1;
        else if (m_mode == 1 && stalled) m_mode = 2;
        else if (m_mode == 2 && !stalled) m_mode = 1;
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        pc_state_e exp_state;
        exp_state = (m_mode == 0) ? PC_BOOT : (m_mode == 1) ? PC_RUN : PC_HOLD;
        chk({tag, ".pc"},    fif.pc_o,                AW'(m_pc));
        chk({tag, ".ce"},    AW'(fif.ce_o),           AW'(m_mode != 0));
        chk({tag, ".err"},   AW'(fif.align_err_o),    AW'(m_err));
        chk({tag, ".state"}, AW'(dut_state),          AW'(exp_state));
    endtask

    // ---------------- driver tasks ----------------
    task automatic cycle(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        chk_all(tag);
    endtask

    task automatic set_in(input logic s, input logic rdy,
                          input logic b, input logic [AW-1:0] bt,
                          input logic e, input logic [AW-1:0] ev);
        stall             = {5'b0, s};
        fif.fetch_ready_i = rdy;
        br_flag           = b;
        br_tgt            = bt;
        ex_flag           = e;
        ex_vec            = ev;
    endtask

    task automatic idle();
        set_in(1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        idle();
        model_reset();
        #2;
        chk_all("reset");

        // Reset release: ce rises, first fetch is the reset vector.
        @(posedge clk); #1;
        rst = 1'b0;
        cycle("boot");
        chk("tp_first_pc", fif.pc_o, 16'h0100);
        cycle("seq1");
        cycle("seq2");
        chk("tp_seq", fif.pc_o, 16'h0108);

        // Branch to 0x2000 while stalled for three cycles.
        set_in(1'b1, 1'b1, 1'b1, 16'h2000, 1'b0, '0);
        cycle("stall_br0");
        set_in(1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
        cycle("stall_br1");
        cycle("stall_br2");
        chk("tp_stall_hold", fif.pc_o, 16'h0108);
        idle();
        cycle("unstall");
        cycle("pend_apply");
        chk("tp_pend_tgt", fif.pc_o, 16'h2000);
        cycle("after_pend");
        chk("tp_after_pend", fif.pc_o, 16'h2004);

        // Branch then exception in the same stall: exception survives.
        set_in(1'b1, 1'b1, 1'b1, 16'h0040, 1'b0, '0);
        cycle("bx_br");
        set_in(1'b1, 1'b1, 1'b0, '0, 1'b1, 16'h0080);
        cycle("bx_ex");
        set_in(1'b1, 1'b1, 1'b1, 16'h0600, 1'b0, '0);
        cycle("bx_br_late");
        idle();
        cycle("bx_unstall");
        cycle("bx_apply");
        chk("tp_excp_wins", fif.pc_o, 16'h0080);

        // fetch_ready low for two cycles at 0x10.
        set_in(1'b0, 1'b1, 1'b1, 16'h0010, 1'b0, '0);
        cycle("rdy_br");
        set_in(1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
        cycle("rdy_lo0");
        cycle("rdy_lo1");
        chk("tp_rdy_hold", fif.pc_o, 16'h0010);
        idle();
        cycle("rdy_back");
        chk("tp_rdy_next", fif.pc_o, 16'h0014);

        // Wrap at the top of the 16-bit space.
        set_in(1'b0, 1'b1, 1'b1, 16'hFFFC, 1'b0, '0);
        cycle("wrap_br");
        idle();
        cycle("wrap");
        chk("tp_wrap", fif.pc_o, 16'h0000);

        // Misaligned branch target is aligned down.
        set_in(1'b0, 1'b1, 1'b1, 16'h1006, 1'b0, '0);
        cycle("mis_br");
        chk("tp_misalign", fif.pc_o, 16'h1004);
        chk("tp_misalign_err", AW'(fif.align_err_o), AW'(ALIGN_EN));
        idle();
        cycle("mis_after");
        chk("tp_err_clear", AW'(fif.align_err_o), 16'h0000);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            set_in(($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 3) != 0),
                   ($urandom_range(0, 5) == 0), AW'($urandom_range(0, 16'hFFFF)),
                   ($urandom_range(0, 9) == 0), AW'($urandom_range(0, 16'hFFFF)));
            cycle("rand");
        end

        // Asynchronous reset in the middle of a stall with a pending redirect.
        set_in(1'b1, 1'b1, 1'b1, 16'h3000, 1'b0, '0);
        cycle("pre_rst0");
        set_in(1'b1, 1'b1, 1'b0, '0, 1'b0, '0);
        cycle("pre_rst1");
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk_all("async_rst");
        chk("tp_async_pc", fif.pc_o, 16'h0100);
        @(posedge clk); #1;
        rst = 1'b0;
        idle();
        cycle("rst_boot");
        cycle("rst_seq");
        chk("tp_pend_dropped", fif.pc_o, 16'h0104);
        cycle("rst_seq2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Global time limit so the bench always ends.
    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
